// File: rtl/l1_line_refill.sv
// l1_line_refill: L1 data cache miss engine.
// Invalidates the target line, optionally writes the dirty victim back to
// memory through the line units' peek port, refills the line word by word
// from memory, then revalidates it under the new tag/set.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   miss_req/addr/dirty         start request, target address, victim dirty
//   victim_addr                 byte address inside the victim line
//   busy, done                  not idle / one-cycle completion pulse
//   line_valid_clr/set          one-cycle valid clear/set of the selected line
//   line_tag, line_set          new tag/set, held from accept to next accept
//   fill_wreq/addr/wdata        refill write port to the line units
//   peek_addr, peek_rdata       victim read port (combinational data)
//   mem_rd/wr/addr/wdata/rdata  memory bus, transfer completes on mem_ack
module l1_line_refill #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SET_W      = 4,
    parameter int unsigned TAG_W      = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_req,
    input  logic [31:0]      miss_addr,
    input  logic             miss_dirty,
    input  logic [31:0]      victim_addr,
    output logic             busy,
    output logic             done,
    output logic             line_valid_clr,
    output logic             line_valid_set,
    output logic [TAG_W-1:0] line_tag,
    output logic [SET_W-1:0] line_set,
    output logic             fill_wreq,
    output logic [31:0]      fill_addr,
    output logic [31:0]      fill_wdata,
    output logic [31:0]      peek_addr,
    input  logic [31:0]      peek_rdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack
);

    localparam int unsigned     CNT_W     = $clog2(LINE_WORDS);
    localparam int unsigned     OFF_W     = CNT_W + 2;
    localparam logic [31:0]     BASE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INVAL,
        S_WB,
        S_FILL,
        S_COMMIT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        fill_base_q, fill_base_d;
    logic [31:0]        victim_base_q, victim_base_d;
    logic               dirty_q, dirty_d;
    logic [TAG_W-1:0]   line_tag_q, line_tag_d;
    logic [SET_W-1:0]   line_set_q, line_set_d;
    logic [31:0]        word_off;

    // Bases are line aligned and cnt stays inside the line, so OR equals add.
    assign word_off  = 32'({cnt_q, 2'b00});
    assign fill_addr = fill_base_q | word_off;
    assign peek_addr = victim_base_q | word_off;
    assign line_tag  = line_tag_q;
    assign line_set  = line_set_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            fill_base_q   <= '0;
            victim_base_q <= '0;
            dirty_q       <= 1'b0;
            line_tag_q    <= '0;
            line_set_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_base_q   <= fill_base_d;
            victim_base_q <= victim_base_d;
            dirty_q       <= dirty_d;
            line_tag_q    <= line_tag_d;
            line_set_q    <= line_set_d;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fill_base_d    = fill_base_q;
        victim_base_d  = victim_base_q;
        dirty_d        = dirty_q;
        line_tag_d     = line_tag_q;
        line_set_d     = line_set_q;
        busy           = 1'b0;
        done           = 1'b0;
        line_valid_clr = 1'b0;
        line_valid_set = 1'b0;
        fill_wreq      = 1'b0;
        fill_wdata     = '0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    fill_base_d   = miss_addr & BASE_MASK;
                    victim_base_d = victim_addr & BASE_MASK;
                    dirty_d       = miss_dirty;
                    line_tag_d    = miss_addr[31 -: TAG_W];
                    line_set_d    = miss_addr[OFF_W +: SET_W];
                    state_d       = S_INVAL;
                end
            end
            S_INVAL: begin
                busy           = 1'b1;
                line_valid_clr = 1'b1;
                cnt_d          = '0;
                state_d        = dirty_q ? S_WB : S_FILL;
            end
            S_WB: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = peek_addr;
                mem_wdata = peek_rdata;
                if (mem_ack) begin
                    // Natural wrap returns cnt to 0 for the refill.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = fill_addr;
                if (mem_ack) begin
                    fill_wreq  = 1'b1;
                    fill_wdata = mem_rdata;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                busy           = 1'b1;
                line_valid_set = 1'b1;
                done           = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_line_refill.sv
// Scoreboard bench for l1_line_refill: stimulus pushes the expected event
// stream (valid clear, victim writes, refill reads, done) and a monitor pops
// and compares each event as the DUT presents it.
module tb_l1_line_refill;

    localparam logic [1:0] K_CLR  = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_dirty = 1'b0;
    logic [31:0] victim_addr = '0;
    logic        busy, done, line_valid_clr, line_valid_set;
    logic [22:0] line_tag;
    logic [3:0]  line_set;
    logic        fill_wreq;
    logic [31:0] fill_addr, fill_wdata, peek_addr, peek_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  rd_total = 0;
    int  rd_base = 0;
    int  ack_mode = 0;

    function automatic logic [31:0] peek_model(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    assign peek_rdata = peek_model(peek_addr);
    assign mem_rdata  = mem_model(mem_addr);

    l1_line_refill dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
        .victim_addr(victim_addr),
        .busy(busy), .done(done),
        .line_valid_clr(line_valid_clr), .line_valid_set(line_valid_set),
        .line_tag(line_tag), .line_set(line_set),
        .fill_wreq(fill_wreq), .fill_addr(fill_addr), .fill_wdata(fill_wdata),
        .peek_addr(peek_addr), .peek_rdata(peek_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ack driver: 0 = tied high, 1 = every third cycle, 2 = 5 wait cycles on refill word 3
    initial begin
        int tick = 0;
        int hold = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                1: begin
                    tick++;
                    mem_ack = (tick % 3 == 0);
                end
                2: begin
                    if (mem_rd && (rd_total - rd_base == 3) && hold < 5) begin
                        mem_ack = 1'b0;
                        hold++;
                    end else begin
                        mem_ack = 1'b1;
                    end
                end
                default: begin
                    mem_ack = 1'b1;
                    hold = 0;
                end
            endcase
        end
    end

    // Monitor: per-cycle protocol rules and scoreboard pops
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [1:0]  prev_kind = '0;
        ev_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
                chk("wreq_rule", 32'(fill_wreq), 32'(mem_rd & mem_ack));
                chk("req_state", 32'((mem_rd | mem_wr) & (~busy | line_valid_clr | done)), 32'd0);
                if (prev_req && !prev_ack && (mem_rd || mem_wr)) begin
                    chk("hold_addr", mem_addr, prev_addr);
                    chk("hold_kind", 32'({mem_rd, mem_wr}), 32'(prev_kind));
                end
                if (line_valid_clr) begin
                    if (sb.size() == 0) chk("unexpected_clr", 32'd1, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("kind_clr", 32'(K_CLR), 32'(e.kind));
                        start_cyc = cyc;
                    end
                end
                if (mem_wr && mem_ack) begin
                    if (sb.size() == 0) chk("unexpected_wr", mem_addr, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("kind_wr", 32'(K_WR), 32'(e.kind));
                        chk("wb_mem_addr", mem_addr, e.addr);
                        chk("wb_peek_addr", peek_addr, e.addr);
                        chk("wb_data", mem_wdata, e.data);
                    end
                end
                if (mem_rd && mem_ack) begin
                    rd_total++;
                    if (sb.size() == 0) chk("unexpected_rd", mem_addr, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("kind_rd", 32'(K_RD), 32'(e.kind));
                        chk("rd_mem_addr", mem_addr, e.addr);
                        chk("rd_fill_addr", fill_addr, e.addr);
                        chk("rd_fill_data", fill_wdata, e.data);
                    end
                end
                if (done) begin
                    if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("kind_done", 32'(K_DONE), 32'(e.kind));
                        chk("tag_set", 32'({line_tag, line_set}), e.addr);
                        chk("valid_set", 32'(line_valid_set), 32'd1);
                        if (e.data != 0) chk("latency", 32'(cyc - start_cyc + 1), e.data);
                    end
                end
                prev_req  = mem_rd | mem_wr;
                prev_ack  = mem_ack;
                prev_addr = mem_addr;
                prev_kind = {mem_rd, mem_wr};
            end
        end
    end

    task automatic push_expected(input logic [31:0] fbase, input logic [31:0] vbase,
                                 input bit dirty, input logic [22:0] tag,
                                 input logic [3:0] set, input int lat);
        sb.push_back('{kind: K_CLR, addr: 32'd0, data: 32'd0});
        if (dirty) begin
            for (int i = 0; i < 8; i++)
                sb.push_back('{kind: K_WR, addr: vbase + 32'(4 * i),
                               data: peek_model(vbase + 32'(4 * i))});
        end
        for (int i = 0; i < 8; i++)
            sb.push_back('{kind: K_RD, addr: fbase + 32'(4 * i),
                           data: mem_model(fbase + 32'(4 * i))});
        sb.push_back('{kind: K_DONE, addr: 32'({tag, set}), data: 32'(lat)});
    endtask

    // Drive one request for a single accept edge
    task automatic issue(input logic [31:0] maddr, input logic [31:0] vaddr, input bit dirty);
        @(posedge clk);
        #1;
        miss_req    = 1'b1;
        miss_addr   = maddr;
        victim_addr = vaddr;
        miss_dirty  = dirty;
        @(posedge clk);
        #1;
        miss_req = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_check();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run(input logic [31:0] maddr, input logic [31:0] vaddr, input bit dirty,
                       input logic [31:0] fbase, input logic [31:0] vbase,
                       input logic [22:0] tag, input logic [3:0] set, input int lat);
        push_expected(fbase, vbase, dirty, tag, set, lat);
        issue(maddr, vaddr, dirty);
        wait_done();
        finish_check();
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'({busy, done, line_valid_clr, line_valid_set}), 32'd0);
        chk({tag, "_req"}, 32'({fill_wreq, mem_rd, mem_wr}), 32'd0);
        chk({tag, "_memaddr"}, mem_addr, 32'd0);
        chk({tag, "_fill_addr"}, fill_addr, 32'd0);
        chk({tag, "_peek_addr"}, peek_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata | fill_wdata, 32'd0);
        chk({tag, "_tagset"}, 32'({line_tag, line_set}), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b1;
        #2 check_idle_zero("reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Clean miss, ack tied high
        ack_mode = 0;
        run(32'h0000_1234, 32'h0, 1'b0, 32'h0000_1220, 32'h0, 23'h000009, 4'h1, 10);

        // Dirty miss, ack every third cycle
        ack_mode = 1;
        run(32'h0000_0080, 32'h8000_0040, 1'b1, 32'h0000_0080, 32'h8000_0040, 23'h0, 4'h4, 0);

        // Five wait states on refill word 3
        ack_mode = 2;
        rd_base = rd_total;
        run(32'h0000_4567, 32'h0, 1'b0, 32'h0000_4560, 32'h0, 23'h000022, 4'hB, 15);

        // miss_req held high through a dirty refill; next accept right after done
        ack_mode = 0;
        push_expected(32'h0000_3000, 32'h0000_2000, 1'b1, 23'h000018, 4'h0, 18);
        @(posedge clk);
        #1;
        miss_req    = 1'b1;
        miss_addr   = 32'h0000_3000;
        victim_addr = 32'h0000_2000;
        miss_dirty  = 1'b1;
        wait_done();
        push_expected(32'h0000_10A0, 32'h0, 1'b0, 23'h000008, 4'h5, 10);
        @(posedge clk);
        #1;
        miss_addr  = 32'h0000_10A0;
        miss_dirty = 1'b0;
        @(negedge clk);
        chk("gap_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        miss_req = 1'b0;
        @(negedge clk);
        chk("gap_reaccept_clr", 32'(line_valid_clr), 32'd1);
        wait_done();
        finish_check();

        // Reset during victim write-back word 2
        push_expected(32'h0000_6000, 32'h0000_5000, 1'b1, 23'h000030, 4'h0, 18);
        issue(32'h0000_6000, 32'h0000_5000, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_idle_zero("abort");
        chk("abort_pending", 32'(sb.size()), 32'd15);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        run(32'h0000_1234, 32'h0, 1'b0, 32'h0000_1220, 32'h0, 23'h000009, 4'h1, 10);

        // Top-of-address-space line
        run(32'hFFFF_FFFF, 32'h0, 1'b0, 32'hFFFF_FFE0, 32'h0, 23'h7FFFFF, 4'hF, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
